// File: rtl/tx_fire_sequencer_pkg.sv
// Beamforming constants and sequencer state encoding shared by the transmit
// sequencer and the receive delay controller.
package tx_fire_sequencer_pkg;

  localparam int DEF_NUM_CHANNELS = 16;
  localparam int DEF_MAX_DELAY    = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tx_fire_sequencer_channel_pulser.sv
// One channel's bipolar burst generator: P half, N half, repeated, then quiet.
module tx_channel_pulser #(
  parameter int HP_WIDTH  = 8,
  parameter int CYC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [HP_WIDTH-1:0]  half_period,
  input  logic [CYC_WIDTH-1:0] num_cycles,
  output logic                 tx_p,
  output logic                 tx_n,
  output logic                 idle
);

  logic                 active;
  logic [HP_WIDTH-1:0]  half_cnt;
  logic [CYC_WIDTH:0]   halves_left;
  logic                 last;
  logic                 start_burst;

  assign last        = active && (half_cnt == '0) && (halves_left == '0);
  assign start_burst = trigger && (num_cycles != '0);
  // Idle already in the final active cycle so the sequencer can close FIRE
  // on the same cycle the longest burst ends.
  assign idle        = !start_burst && (!active || last);

  always_ff @(posedge clk) begin
    if (reset) begin
      active      <= 1'b0;
      half_cnt    <= '0;
      halves_left <= '0;
      tx_p        <= 1'b0;
      tx_n        <= 1'b0;
    end else if (start_burst && !active) begin
      active      <= 1'b1;
      tx_p        <= 1'b1;
      tx_n        <= 1'b0;
      half_cnt    <= half_period - HP_WIDTH'(1);
      halves_left <= {num_cycles, 1'b0} - 1'b1;
    end else if (active) begin
      if (half_cnt == '0) begin
        if (halves_left == '0) begin
          active <= 1'b0;
          tx_p   <= 1'b0;
          tx_n   <= 1'b0;
        end else begin
          tx_p        <= ~tx_p;
          tx_n        <= ~tx_n;
          halves_left <= halves_left - 1'b1;
          half_cnt    <= half_period - HP_WIDTH'(1);
        end
      end else begin
        half_cnt <= half_cnt - HP_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/tx_fire_sequencer.sv
// Transmit firing sequencer: delay table, IDLE/ARM/FIRE/DONE control, master
// time counter and one bipolar pulser per channel.
module tx_fire_sequencer
  import tx_fire_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int MAX_DELAY    = DEF_MAX_DELAY,
  parameter int DELAY_WIDTH  = $clog2(MAX_DELAY),
  parameter int HP_WIDTH     = 8,
  parameter int CYC_WIDTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            delay_wr_en,
  input  logic [$clog2(NUM_CHANNELS)-1:0] delay_wr_addr,
  input  logic [DELAY_WIDTH-1:0]          delay_wr_data,
  input  logic                            start,
  input  logic [HP_WIDTH-1:0]             half_period,
  input  logic [CYC_WIDTH-1:0]            num_cycles,
  input  logic [NUM_CHANNELS-1:0]         chan_en,
  output logic [NUM_CHANNELS-1:0]         tx_p,
  output logic [NUM_CHANNELS-1:0]         tx_n,
  output logic                            t0,
  output logic                            busy,
  output logic                            done
);

  localparam logic [DELAY_WIDTH-1:0] T_LAST = DELAY_WIDTH'(MAX_DELAY - 1);

  seq_state_t                  state;
  logic [DELAY_WIDTH-1:0]      t;
  logic                        t_held;
  logic [DELAY_WIDTH-1:0]      delay_tab [NUM_CHANNELS];
  logic [HP_WIDTH-1:0]         h_q;
  logic [CYC_WIDTH-1:0]        c_q;
  logic [NUM_CHANNELS-1:0]     en_q;
  logic [NUM_CHANNELS-1:0]     trig;
  logic [NUM_CHANNELS-1:0]     idle;
  logic                        all_idle;

  assign all_idle = &idle;

  // t_held keeps a delay of MAX_DELAY-1 from retriggering while t is saturated.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign trig[i] = (state == ST_FIRE) && !t_held && en_q[i] && (t == delay_tab[i]);

    tx_channel_pulser #(
      .HP_WIDTH (HP_WIDTH),
      .CYC_WIDTH(CYC_WIDTH)
    ) u_pulser (
      .clk        (clk),
      .reset      (reset),
      .trigger    (trig[i]),
      .half_period(h_q),
      .num_cycles (c_q),
      .tx_p       (tx_p[i]),
      .tx_n       (tx_n[i]),
      .idle       (idle[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      t      <= '0;
      t_held <= 1'b0;
      h_q    <= HP_WIDTH'(1);
      c_q    <= '0;
      en_q   <= '0;
      t0     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) delay_tab[i] <= '0;
    end else begin
      t0   <= 1'b0;
      done <= 1'b0;
      if (state == ST_IDLE && delay_wr_en && (int'(delay_wr_addr) < NUM_CHANNELS))
        delay_tab[delay_wr_addr] <= delay_wr_data;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ARM;
            busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          h_q    <= (half_period == '0) ? HP_WIDTH'(1) : half_period;
          c_q    <= num_cycles;
          en_q   <= chan_en;
          t      <= '0;
          t_held <= 1'b0;
          t0     <= 1'b1;
          state  <= ST_FIRE;
        end
        ST_FIRE: begin
          if (t == T_LAST) begin
            t_held <= 1'b1;
            if (all_idle) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            t <= t + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          t     <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Directed bench for tx_fire_sequencer: per-cycle capture of each firing
// sequence relative to t0, checked against hand-derived burst timing.
module tb_tx_fire_sequencer;
  localparam int N    = 16;
  localparam int HMAX = 600;

  logic         clk = 1'b0;
  logic         reset;
  logic         delay_wr_en;
  logic [3:0]   delay_wr_addr;
  logic [7:0]   delay_wr_data;
  logic         start;
  logic [7:0]   half_period;
  logic [3:0]   num_cycles;
  logic [N-1:0] chan_en;
  logic [N-1:0] tx_p;
  logic [N-1:0] tx_n;
  logic         t0;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] p_hist [HMAX];
  logic [N-1:0] n_hist [HMAX];
  int done_cyc, overlap, tx_any, busy_low, t0_extra;

  tx_fire_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .delay_wr_en  (delay_wr_en),
    .delay_wr_addr(delay_wr_addr),
    .delay_wr_data(delay_wr_data),
    .start        (start),
    .half_period  (half_period),
    .num_cycles   (num_cycles),
    .chan_en      (chan_en),
    .tx_p         (tx_p),
    .tx_n         (tx_n),
    .t0           (t0),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_delay(input logic [3:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    delay_wr_en = 1'b1; delay_wr_addr = addr; delay_wr_data = data;
    @(posedge clk); #1;
    delay_wr_en = 1'b0;
  endtask

  // Fires one sequence and records tx per cycle, index 0 = t0 cycle.
  // inject_cyc >= 0 drives a table write (ch2=99) plus start during FIRE.
  task automatic run_seq(input int inject_cyc, input logic wr_at_start,
                         input logic [3:0] wa, input logic [7:0] wd);
    int cyc;
    for (int i = 0; i < HMAX; i++) begin
      p_hist[i] = '0;
      n_hist[i] = '0;
    end
    done_cyc = -1; overlap = 0; tx_any = 0; busy_low = 0; t0_extra = 0;
    @(posedge clk); #1;
    start = 1'b1; delay_wr_en = wr_at_start; delay_wr_addr = wa; delay_wr_data = wd;
    @(posedge clk); #1;
    start = 1'b0; delay_wr_en = 1'b0;
    @(negedge clk);
    check("arm_busy", busy, 1);
    check("arm_t0", t0, 0);
    @(negedge clk);
    check("t0_first", t0, 1);
    cyc = 0;
    while (cyc < HMAX && done_cyc < 0) begin
      p_hist[cyc] = tx_p;
      n_hist[cyc] = tx_n;
      if ((tx_p & tx_n) != '0) overlap++;
      if ((tx_p | tx_n) != '0) tx_any++;
      if (!busy) busy_low++;
      if (t0 && cyc != 0) t0_extra++;
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (cyc == inject_cyc) begin
          start = 1'b1; delay_wr_en = 1'b1; delay_wr_addr = 4'd2; delay_wr_data = 8'd99;
        end else begin
          start = 1'b0; delay_wr_en = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0; delay_wr_en = 1'b0;
    check("no_overlap", overlap, 0);
    check("t0_once", t0_extra, 0);
    check("busy_span", busy_low, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    reset = 1'b1; delay_wr_en = 1'b0; delay_wr_addr = '0; delay_wr_data = '0;
    start = 1'b0; half_period = 8'd2; num_cycles = 4'd1; chan_en = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tx_p", tx_p, 0);
    check("rst_tx_n", tx_n, 0);
    check("rst_t0", t0, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Basic burst: ch0=0, ch1=5, all others 0, H=2, C=1
    write_delay(4'd0, 8'd0);
    write_delay(4'd1, 8'd5);
    run_seq(-1, 1'b0, 4'd0, 8'd0);
    check("b_p0", p_hist[0], 16'h0000);
    check("b_p1", p_hist[1], 16'hFFFD);
    check("b_p2", p_hist[2], 16'hFFFD);
    check("b_p3", p_hist[3], 16'h0000);
    check("b_n3", n_hist[3], 16'hFFFD);
    check("b_n4", n_hist[4], 16'hFFFD);
    check("b_n5", n_hist[5], 16'h0000);
    check("b_ch1_p5", p_hist[5], 16'h0000);
    check("b_ch1_p6", p_hist[6], 16'h0002);
    check("b_ch1_p7", p_hist[7], 16'h0002);
    check("b_ch1_n8", n_hist[8], 16'h0002);
    check("b_ch1_n9", n_hist[9], 16'h0002);
    check("b_done", done_cyc, 256);

    // H=0 treated as 1, C=2, ch3 delay 10 only
    write_delay(4'd3, 8'd10);
    half_period = 8'd0; num_cycles = 4'd2; chan_en = 16'h0008;
    run_seq(-1, 1'b0, 4'd0, 8'd0);
    check("h0_p10", p_hist[10], 16'h0000);
    check("h0_p11", p_hist[11], 16'h0008);
    check("h0_n12", n_hist[12], 16'h0008);
    check("h0_p13", p_hist[13], 16'h0008);
    check("h0_n14", n_hist[14], 16'h0008);
    check("h0_off15", p_hist[15] | n_hist[15], 16'h0000);
    check("h0_active", tx_any, 4);
    check("h0_done", done_cyc, 256);

    // ch7 delay 255, H=4, C=3: FIRE stretched to 280 cycles
    write_delay(4'd7, 8'd255);
    half_period = 8'd4; num_cycles = 4'd3; chan_en = 16'h0080;
    run_seq(-1, 1'b0, 4'd0, 8'd0);
    check("ext_p255", p_hist[255], 16'h0000);
    check("ext_p256", p_hist[256], 16'h0080);
    check("ext_p259", p_hist[259], 16'h0080);
    check("ext_n260", n_hist[260], 16'h0080);
    check("ext_p272", p_hist[272], 16'h0080);
    check("ext_n279", n_hist[279], 16'h0080);
    check("ext_active", tx_any, 24);
    check("ext_done", done_cyc, 280);

    // C=0: no pulses, sequence still runs
    half_period = 8'd2; num_cycles = 4'd0; chan_en = 16'h0001;
    run_seq(-1, 1'b0, 4'd0, 8'd0);
    check("c0_no_tx", tx_any, 0);
    check("c0_done", done_cyc, 256);

    // Write and start during FIRE are dropped
    write_delay(4'd2, 8'd20);
    half_period = 8'd1; num_cycles = 4'd1; chan_en = 16'h0004;
    run_seq(30, 1'b0, 4'd0, 8'd0);
    check("ign_p21", p_hist[21], 16'h0004);
    check("ign_n22", n_hist[22], 16'h0004);
    check("ign_done", done_cyc, 256);
    repeat (3) @(negedge clk);
    check("ign_no_queue", busy, 0);
    run_seq(-1, 1'b0, 4'd0, 8'd0);
    check("ign2_p21", p_hist[21], 16'h0004);
    check("ign2_p100", p_hist[100], 16'h0000);

    // Reset in the middle of a burst
    half_period = 8'd4; num_cycles = 4'd3; chan_en = 16'hFFFF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    repeat (8) @(negedge clk);
    check("mid_active", (tx_p | tx_n) != '0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_tx_p", tx_p, 0);
    check("mid_tx_n", tx_n, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    reset = 1'b0;

    // Cleared table, plus write-with-start landing ch5=3
    half_period = 8'd1; num_cycles = 4'd1; chan_en = 16'hFFFF;
    run_seq(-1, 1'b1, 4'd5, 8'd3);
    check("clr_p1", p_hist[1], 16'hFFDF);
    check("clr_n2", n_hist[2], 16'hFFDF);
    check("clr_p3", p_hist[3], 16'h0000);
    check("clr_ch5_p4", p_hist[4], 16'h0020);
    check("clr_ch5_n5", n_hist[5], 16'h0020);
    check("clr_done", done_cyc, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fire_sequencer.md
Name: tx_fire_sequencer

Overview:
- Transmit-side counterpart of the receive delay controller. Holds a per-channel transmit-delay table and, on start, fires a bipolar burst on every enabled channel, each offset by its own delay, to focus or steer the transmitted wave.
- Emits a t0 marker so the receive beamforming chain aligns to the same time origin.
- Sits between the delay-calculation/control logic (table writer) and the per-element pulser drivers.

Parameters:
- NUM_CHANNELS, 16, number of transducer channels.
- MAX_DELAY, 256, delay range in clk cycles; delays are 0..MAX_DELAY-1.
- DELAY_WIDTH, $clog2(MAX_DELAY) = 8, width of one delay entry.
- HP_WIDTH, 8, width of the half-period setting.
- CYC_WIDTH, 4, width of the burst-cycle-count setting.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- delay_wr_en  input  1  write one delay-table entry this cycle
- delay_wr_addr  input  $clog2(NUM_CHANNELS)  channel index for the write
- delay_wr_data  input  DELAY_WIDTH  transmit delay for that channel, in cycles
- start  input  1  request a firing sequence
- half_period  input  HP_WIDTH  duration of each pulse half, in cycles
- num_cycles  input  CYC_WIDTH  number of full P/N periods per burst
- chan_en  input  NUM_CHANNELS  per-channel enable mask (transmit apodization)
- tx_p  output  NUM_CHANNELS  positive pulser drive, registered
- tx_n  output  NUM_CHANNELS  negative pulser drive, registered
- t0  output  1  one-cycle marker at firing time origin
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Reset values:
  - tx_p, tx_n, t0, busy and done are 0.
  - The state machine is in IDLE and the master counter t is 0.
  - Delay-table contents are 0 after reset.
- Delay table:
  - A write takes effect only when delay_wr_en=1 and the state is IDLE.
  - Writes in any other state are dropped.
  - Addresses >= NUM_CHANNELS are ignored.
  - A write and a start in the same IDLE cycle: the write lands, and the sequence uses the new value.
- State machine IDLE -> ARM -> FIRE -> DONE -> IDLE:
  - IDLE: on start=1, go to ARM. start in any other state is ignored (no queuing).
  - ARM (1 cycle):
    - Latch H = max(half_period, 1), C = num_cycles and the chan_en mask.
    - Inputs may change after ARM without effect.
  - FIRE:
    - t runs 0,1,2,...; t0=1 in the first FIRE cycle only.
    - t saturates at MAX_DELAY-1.
    - Leave FIRE on the cycle where t==MAX_DELAY-1 and every channel pulser is idle.
  - DONE (1 cycle): done=1, then return to IDLE.
- busy=1 in ARM, FIRE and DONE.
- Latency:
  - start sampled in IDLE at edge k gives ARM in cycle k+1 and FIRE/t0 in cycle k+2.
  - For an enabled channel i with delay d, tx_p[i] first goes high exactly d+1 cycles after the t0 cycle.
- Burst shape per channel:
  - tx_p high for H cycles, then tx_n high for H cycles; repeat C times; then both low.
  - Active length is 2*H*C cycles.
  - tx_p[i] and tx_n[i] are never both 1.
- Disabled channels and C=0:
  - A channel with chan_en[i]=0 stays low for the whole sequence.
  - With C=0 no channel pulses, but t0, busy and done still sequence normally.
- Sequence length: FIRE lasts max(MAX_DELAY, latest_start + 2*H*C) cycles, where latest_start is the largest enabled delay + 1.
- Width rules:
  - Per-channel half counter is HP_WIDTH bits; half-cycle counter is CYC_WIDTH+1 bits.
  - The master counter is DELAY_WIDTH bits and does not wrap.
- Reset mid-FIRE: all outputs are 0 at the next edge, state returns to IDLE and the delay table is cleared.

Decomposition:
- Shared package (beamforming): the state encoding IDLE/ARM/FIRE/DONE and the default channel count and delay range, shared with the receive delay controller so both ends agree on NUM_CHANNELS and MAX_DELAY.
- Sub-module tx_channel_pulser, instantiated NUM_CHANNELS times via generate:
  - Inputs: trigger (t==delay[i] and enabled in FIRE), H, C.
  - Outputs: registered tx_p, tx_n and an idle flag.
- The top level holds the table, the state machine, t, t0, busy and done.

Test Plan:
- Reset, write delays ch0=0 and ch1=5, all other channels 0, chan_en=0xFFFF, H=2, C=1, start:
  - t0 two cycles after start.
  - ch0 tx_p high t0+1..t0+2, tx_n high t0+3..t0+4.
  - ch1 tx_p high t0+6..t0+7.
  - done after t reaches 255.
- H=0, C=2, ch3 delay 10:
  - H is treated as 1; ch3 shows P,N,P,N one cycle each starting t0+11.
  - tx_p&tx_n is never asserted.
- ch7 delay 255, H=4, C=3:
  - FIRE is extended until ch7 completes its 24-cycle burst.
  - done is high exactly 1 cycle afterwards, then busy drops.
- chan_en=0x0001, C=0, start:
  - No tx activity at all; t0 and done are still produced; busy spans ARM through DONE.
- During FIRE, write ch2=99 and pulse start:
  - Both are ignored.
  - A second run after IDLE still uses ch2's old delay.
- Assert reset mid-burst:
  - All tx outputs, busy and done are 0 next cycle.
  - A fresh start afterwards fires with all delays 0.
